// File: rtl/jtag_pkg.sv
// Shared definitions for the boundary-scan register chain: instruction codes
// and the decoded per-cycle DR operation set.
package jtag_pkg;

    localparam int BSR_INST_W = 2;

    localparam logic [BSR_INST_W-1:0] INST_EXTEST = 2'b00;
    localparam logic [BSR_INST_W-1:0] INST_SAMPLE = 2'b01;
    localparam logic [BSR_INST_W-1:0] INST_BYPASS = 2'b10;
    localparam logic [BSR_INST_W-1:0] INST_INTEST = 2'b11;

    // At most one field is set: the single operation that acts this cycle.
    typedef struct packed {
        logic bsr_capture;
        logic bsr_shift;
        logic bsr_update;
        logic byp_capture;
        logic byp_shift;
    } dr_ops_t;

    // Capture beats shift beats update; BYPASS steers capture/shift to the
    // bypass bit and suppresses update entirely.
    function automatic dr_ops_t decode_dr_ops(
        input logic [BSR_INST_W-1:0] inst,
        input logic                  capture,
        input logic                  shift,
        input logic                  update
    );
        dr_ops_t ops;
        logic    bypass;
        ops    = '0;
        bypass = (inst == INST_BYPASS);
        if (capture) begin
            if (bypass) begin
                ops.byp_capture = 1'b1;
            end else begin
                ops.bsr_capture = 1'b1;
            end
        end else if (shift) begin
            if (bypass) begin
                ops.byp_shift = 1'b1;
            end else begin
                ops.bsr_shift = 1'b1;
            end
        end else if (update && !bypass) begin
            ops.bsr_update = 1'b1;
        end
        return ops;
    endfunction

endpackage

// File: rtl/jtag_bsr_chain_cell.sv
// One boundary-scan cell: a capture/shift flop feeding the serial chain and
// an update flop holding the value presented to the pin/core mux.
module bsr_cell (
    input  logic TCLK,
    input  logic TRST,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic par_in,
    input  logic ser_in,
    output logic ser_out,
    output logic upd_out
);

    logic cap_q;
    logic cap_d;
    logic upd_q;
    logic upd_d;

    always_comb begin
        cap_d = cap_q;
        upd_d = upd_q;
        if (capture) begin
            cap_d = par_in;
        end else if (shift) begin
            cap_d = ser_in;
        end else if (update) begin
            upd_d = cap_q;
        end
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            cap_q <= 1'b0;
            upd_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            upd_q <= upd_d;
        end
    end

    assign ser_out = cap_q;
    assign upd_out = upd_q;

endmodule

// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register chain: N_IN input cells then N_OUT output cells
// between TDI and TDO, plus a bypass bit and the pin/core output muxes.
module jtag_bsr_chain
    import jtag_pkg::*;
#(
    parameter int N_IN  = 36,
    parameter int N_OUT = 39
) (
    input  logic                  TCLK,
    input  logic                  TRST,
    input  logic [BSR_INST_W-1:0] inst,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    input  logic                  TDI,
    output logic                  TDO,
    input  logic [N_IN-1:0]       pin_in,
    output logic [N_IN-1:0]       core_in,
    input  logic [N_OUT-1:0]      core_out,
    output logic [N_OUT-1:0]      pin_out
);

    localparam int W = N_IN + N_OUT;

    if (N_IN < 1 || N_OUT < 1) begin : g_param_check
        $error("jtag_bsr_chain: N_IN (%0d) and N_OUT (%0d) must both be at least 1", N_IN, N_OUT);
    end

    dr_ops_t        ops;
    logic [W-1:0]   par_in;
    logic [W-1:0]   ser_in;
    logic [W-1:0]   sreg;
    logic [W-1:0]   ureg;
    logic           byp_q;
    logic           byp_d;

    always_comb begin
        ops = decode_dr_ops(inst, capture_dr, shift_dr, update_dr);
    end

    // Cell 0 sits next to TDI, so the chain shifts towards the top index.
    assign par_in = {core_out, pin_in};
    assign ser_in = {sreg[W-2:0], TDI};

    genvar gi;
    for (gi = 0; gi < W; gi++) begin : g_cell
        bsr_cell u_cell (
            .TCLK    (TCLK),
            .TRST    (TRST),
            .capture (ops.bsr_capture),
            .shift   (ops.bsr_shift),
            .update  (ops.bsr_update),
            .par_in  (par_in[gi]),
            .ser_in  (ser_in[gi]),
            .ser_out (sreg[gi]),
            .upd_out (ureg[gi])
        );
    end

    always_comb begin
        byp_d = byp_q;
        if (ops.byp_capture) begin
            byp_d = 1'b0;
        end else if (ops.byp_shift) begin
            byp_d = TDI;
        end
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            byp_q <= 1'b0;
        end else begin
            byp_q <= byp_d;
        end
    end

    // Muxes follow inst with no register so an instruction change is visible at once.
    assign TDO     = (inst == INST_BYPASS) ? byp_q : sreg[W-1];
    assign core_in = (inst == INST_INTEST) ? ureg[N_IN-1:0] : pin_in;
    assign pin_out = (inst == INST_EXTEST) ? ureg[W-1:N_IN] : core_out;

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// Bench for jtag_bsr_chain: a 4+4 instance checked every cycle against a
// behavioural model, plus a default-size instance for end-to-end latency.
module tb_jtag_bsr_chain;

    localparam logic [1:0] I_EXT = 2'b00;
    localparam logic [1:0] I_SMP = 2'b01;
    localparam logic [1:0] I_BYP = 2'b10;
    localparam logic [1:0] I_INT = 2'b11;

    logic       TCLK = 1'b0;
    logic       trst = 1'b0;
    logic [1:0] inst = I_EXT;
    logic       cap  = 1'b0;
    logic       sh   = 1'b0;
    logic       upd  = 1'b0;
    logic       tdi  = 1'b0;
    logic       tdo;
    logic [3:0] pin_in   = 4'h0;
    logic [3:0] core_in;
    logic [3:0] core_out = 4'h0;
    logic [3:0] pin_out;

    logic        b_trst = 1'b1;
    logic [1:0]  b_inst = I_SMP;
    logic        b_cap  = 1'b0;
    logic        b_sh   = 1'b0;
    logic        b_upd  = 1'b0;
    logic        b_tdi  = 1'b0;
    logic        b_tdo;
    logic [35:0] b_pin_in   = 36'h0;
    logic [35:0] b_core_in;
    logic [38:0] b_core_out = 39'h0;
    logic [38:0] b_pin_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic check_en = 1'b0;

    logic [7:0] m_sreg = 8'h0;
    logic [7:0] m_ureg = 8'h0;
    logic       m_byp  = 1'b0;

    always #5 TCLK = ~TCLK;

    jtag_bsr_chain #(.N_IN(4), .N_OUT(4)) u_small (
        .TCLK(TCLK), .TRST(trst), .inst(inst),
        .capture_dr(cap), .shift_dr(sh), .update_dr(upd),
        .TDI(tdi), .TDO(tdo),
        .pin_in(pin_in), .core_in(core_in),
        .core_out(core_out), .pin_out(pin_out)
    );

    jtag_bsr_chain u_big (
        .TCLK(TCLK), .TRST(b_trst), .inst(b_inst),
        .capture_dr(b_cap), .shift_dr(b_sh), .update_dr(b_upd),
        .TDI(b_tdi), .TDO(b_tdo),
        .pin_in(b_pin_in), .core_in(b_core_in),
        .core_out(b_core_out), .pin_out(b_pin_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the chain as an 8-bit word, TDI entering bit 0.
    always @(posedge TCLK) begin
        if (trst) begin
            m_sreg <= 8'h0;
            m_ureg <= 8'h0;
            m_byp  <= 1'b0;
        end else if (cap) begin
            if (inst == I_BYP) m_byp <= 1'b0;
            else               m_sreg <= {core_out, pin_in};
        end else if (sh) begin
            if (inst == I_BYP) m_byp <= tdi;
            else               m_sreg <= {m_sreg[6:0], tdi};
        end else if (upd && inst != I_BYP) begin
            m_ureg <= m_sreg;
        end
    end

    always begin
        @(posedge TCLK);
        #1;
        if (check_en) begin
            chk("tdo", 64'(tdo), 64'((inst == I_BYP) ? m_byp : m_sreg[7]));
            chk("core_in", 64'(core_in), 64'((inst == I_INT) ? m_ureg[3:0] : pin_in));
            chk("pin_out", 64'(pin_out), 64'((inst == I_EXT) ? m_ureg[7:4] : core_out));
        end
    end

    task automatic step(input logic t, input logic [1:0] i, input logic c, input logic s,
                        input logic u, input logic d);
        trst = t; inst = i; cap = c; sh = s; upd = u; tdi = d;
        @(posedge TCLK);
        #2;
        $display("t=%0t trst=%b inst=%b cap=%b sh=%b upd=%b tdi=%b pin_in=%h core_out=%h -> tdo=%b core_in=%h pin_out=%h",
                 $time, t, i, c, s, u, d, pin_in, core_out, tdo, core_in, pin_out);
    endtask

    initial begin
        logic [7:0] smp;
        logic [7:0] pre;
        logic [3:0] bp;
        int first_hit;

        check_en   = 1'b1;
        b_core_out = {7'h0, $urandom()};
        b_pin_in   = {4'h0, $urandom()};

        // Reset overrides a simultaneous shift of a 1.
        step(1'b1, I_EXT, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_tdo", 64'(tdo), 64'd0);
        chk("rst_pin_out", 64'(pin_out), 64'h0);
        chk("rst_core_in", 64'(core_in), 64'(pin_in));
        chk("big_rst_tdo", 64'(b_tdo), 64'd0);
        chk("big_rst_pin_out", 64'(b_pin_out), 64'(b_core_out));
        chk("big_rst_core_in", 64'(b_core_in), 64'(b_pin_in));
        b_trst = 1'b0;

        // SAMPLE capture then shift out MSB first.
        pin_in = 4'hA; core_out = 4'h5; smp = 8'h5A;
        step(1'b0, I_SMP, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sample_bit7", 64'(tdo), 64'(smp[7]));
        for (int k = 6; k >= 0; k--) begin
            step(1'b0, I_SMP, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("sample_bit", 64'(tdo), 64'(smp[k]));
        end

        // Preload C3 then update; view through EXTEST, SAMPLE, INTEST.
        pre = 8'hC3;
        for (int k = 7; k >= 0; k--) step(1'b0, I_SMP, 1'b0, 1'b1, 1'b0, pre[k]);
        step(1'b0, I_SMP, 1'b0, 1'b0, 1'b1, 1'b0);
        pin_in = 4'h6;
        step(1'b0, I_EXT, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("extest_pin_out", 64'(pin_out), 64'hC);
        chk("extest_core_in", 64'(core_in), 64'h6);
        step(1'b0, I_SMP, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sample_pin_out", 64'(pin_out), 64'h5);
        step(1'b0, I_INT, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("intest_core_in", 64'(core_in), 64'h3);
        chk("intest_pin_out", 64'(pin_out), 64'h5);
        core_out = 4'h9;
        step(1'b0, I_INT, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("intest_capture_tdo", 64'(tdo), 64'd1);

        // BYPASS: one-cycle lag, update ignored, sreg untouched.
        step(1'b0, I_BYP, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("byp_capture_tdo", 64'(tdo), 64'd0);
        bp = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, I_BYP, 1'b0, 1'b1, 1'b0, bp[k]);
            chk("byp_lag", 64'(tdo), 64'(bp[k]));
        end
        step(1'b0, I_BYP, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, I_EXT, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("byp_ureg_hold", 64'(pin_out), 64'hC);
        step(1'b0, I_SMP, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("byp_sreg_hold", 64'(tdo), 64'd1);

        // Capture beats shift: sreg becomes 8F, not the shifted 2D.
        pin_in = 4'hF; core_out = 4'h8;
        step(1'b0, I_SMP, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("prio_capture", 64'(tdo), 64'd1);

        // Reset after 3 of 8 shifts.
        for (int k = 0; k < 3; k++) step(1'b0, I_SMP, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, I_EXT, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("midshift_rst_tdo", 64'(tdo), 64'd0);
        chk("midshift_rst_pin_out", 64'(pin_out), 64'h0);

        // Walking 1 through the 75-cell chain.
        first_hit = 0;
        for (int n = 1; n <= 100; n++) begin
            b_sh  = 1'b1;
            b_tdi = (n == 1);
            step(1'b0, I_SMP, 1'b0, 1'b0, 1'b0, 1'b0);
            if (b_tdo === 1'b1 && first_hit == 0) first_hit = n;
        end
        b_sh = 1'b0; b_tdi = 1'b0;
        chk("walk1_latency", 64'(first_hit), 64'd75);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            pin_in   = 4'($urandom());
            core_out = 4'($urandom());
            step(($urandom_range(0, 63) == 0), 2'($urandom()), 1'($urandom()),
                 1'($urandom()), 1'($urandom()), 1'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
